// File: rtl/id_arb_pkg.sv
// Shared types for the decode-to-issue arbiter: FSM states, entry source tags
// and the packed output-register layout.
package id_arb_pkg;

  // Widest payload the output register carries; narrower DATA_W is zero-extended.
  localparam int ID_ARB_DATA_W = 64;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  typedef enum logic {
    SRC_FETCH  = 1'b0,
    SRC_INJECT = 1'b1
  } issue_src_e;

  typedef struct packed {
    logic                     valid;
    issue_src_e               src;
    logic [ID_ARB_DATA_W-1:0] data;
  } issue_reg_t;

endpackage

// File: rtl/id_arb_starve_cnt.sv
// Saturating starvation counter: counts cycles the inject port loses, sat_o
// raises once LIMIT is reached and holds until clr_i.
module id_arb_starve_cnt #(
  parameter int LIMIT = 4,
  parameter int CNT_W = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign sat_o = (cnt_q == CNT_W'(LIMIT));

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !sat_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/id_issue_arbiter.sv
// Arbitrates fetch vs. injected micro-ops into the single issue register.
// Optional perf counters are enabled with `define ID_ISSUE_ARB_PERF_EN.
module id_issue_arbiter
  import id_arb_pkg::*;
#(
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              fetch_valid_i,
  input  logic [DATA_W-1:0] fetch_data_i,
  output logic              fetch_ready_o,
  input  logic              inject_valid_i,
  input  logic [DATA_W-1:0] inject_data_i,
  input  logic              inject_last_i,
  output logic              inject_ready_o,
  output logic              issue_valid_o,
  output logic [DATA_W-1:0] issue_data_o,
  output logic              issue_src_o,
  input  logic              issue_ack_i,
  output logic              lock_o
`ifdef ID_ISSUE_ARB_PERF_EN
  ,
  output logic [31:0]       perf_fetch_grants_o,
  output logic [31:0]       perf_inject_grants_o,
  output logic [31:0]       perf_starve_forced_o
`endif
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e state_q, state_d;
  issue_reg_t issue_q, issue_d;
  logic       space;
  logic       fetch_grant, inject_grant;
  logic       starve_inc, starve_clr, starve_sat;

  assign space = !issue_q.valid || issue_ack_i;

  // Reset and flush both suppress every grant in the cycle they are seen.
  always_comb begin
    fetch_grant  = 1'b0;
    inject_grant = 1'b0;
    if (!rst_i && !flush_i && space) begin
      if (state_q == ARB_LOCKED) begin
        inject_grant = inject_valid_i;
      end else begin
        inject_grant = inject_valid_i && (!fetch_valid_i || starve_sat);
        fetch_grant  = fetch_valid_i && !inject_grant;
      end
    end
  end

  assign fetch_ready_o  = fetch_grant;
  assign inject_ready_o = inject_grant;

  assign starve_inc = inject_valid_i && (state_q == ARB_IDLE) && (fetch_grant || !space);
  assign starve_clr = flush_i || inject_grant;

  id_arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT),
    .CNT_W (CNT_W)
  ) u_starve_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (starve_inc),
    .clr_i (starve_clr),
    .sat_o (starve_sat)
  );

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ARB_IDLE;
    end else begin
      case (state_q)
        ARB_IDLE:   if (inject_grant && !inject_last_i) state_d = ARB_LOCKED;
        ARB_LOCKED: if (inject_grant && inject_last_i)  state_d = ARB_IDLE;
        default:    state_d = ARB_IDLE;
      endcase
    end
  end

  // Flush drops the entry but leaves data/src untouched; only reset clears them.
  always_comb begin
    issue_d = issue_q;
    if (flush_i) begin
      issue_d.valid = 1'b0;
    end else if (inject_grant) begin
      issue_d.valid = 1'b1;
      issue_d.src   = SRC_INJECT;
      issue_d.data  = ID_ARB_DATA_W'(inject_data_i);
    end else if (fetch_grant) begin
      issue_d.valid = 1'b1;
      issue_d.src   = SRC_FETCH;
      issue_d.data  = ID_ARB_DATA_W'(fetch_data_i);
    end else if (issue_ack_i) begin
      issue_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      issue_q <= '0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
    end
  end

  assign issue_valid_o = issue_q.valid;
  assign issue_data_o  = issue_q.data[DATA_W-1:0];
  assign issue_src_o   = issue_q.src;
  assign lock_o        = (state_q == ARB_LOCKED);

`ifdef ID_ISSUE_ARB_PERF_EN
  logic [31:0] perf_fetch_q, perf_inject_q, perf_forced_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_fetch_q  <= '0;
      perf_inject_q <= '0;
      perf_forced_q <= '0;
    end else begin
      if (fetch_grant)  perf_fetch_q  <= perf_fetch_q + 32'd1;
      if (inject_grant) perf_inject_q <= perf_inject_q + 32'd1;
      if (inject_grant && (state_q == ARB_IDLE) && fetch_valid_i && starve_sat) begin
        perf_forced_q <= perf_forced_q + 32'd1;
      end
    end
  end

  assign perf_fetch_grants_o  = perf_fetch_q;
  assign perf_inject_grants_o = perf_inject_q;
  assign perf_starve_forced_o = perf_forced_q;
`endif

endmodule

// File: tb/tb_id_issue_arbiter.sv
// Self-checking bench for id_issue_arbiter: a reference model predicts grants
// and a scoreboard queue holds the entries expected in the issue register.
module tb_id_issue_arbiter;

  localparam int DW    = 64;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          flush_i;
  logic          fetch_valid_i;
  logic [DW-1:0] fetch_data_i;
  logic          fetch_ready_o;
  logic          inject_valid_i;
  logic [DW-1:0] inject_data_i;
  logic          inject_last_i;
  logic          inject_ready_o;
  logic          issue_valid_o;
  logic [DW-1:0] issue_data_o;
  logic          issue_src_o;
  logic          issue_ack_i;
  logic          lock_o;
`ifdef ID_ISSUE_ARB_PERF_EN
  logic [31:0]   perf_fetch_grants_o;
  logic [31:0]   perf_inject_grants_o;
  logic [31:0]   perf_starve_forced_o;
`endif

  always #5 clk = ~clk;

  id_issue_arbiter #(
    .DATA_W       (DW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .fetch_valid_i  (fetch_valid_i),
    .fetch_data_i   (fetch_data_i),
    .fetch_ready_o  (fetch_ready_o),
    .inject_valid_i (inject_valid_i),
    .inject_data_i  (inject_data_i),
    .inject_last_i  (inject_last_i),
    .inject_ready_o (inject_ready_o),
    .issue_valid_o  (issue_valid_o),
    .issue_data_o   (issue_data_o),
    .issue_src_o    (issue_src_o),
    .issue_ack_i    (issue_ack_i),
    .lock_o         (lock_o)
`ifdef ID_ISSUE_ARB_PERF_EN
    ,
    .perf_fetch_grants_o  (perf_fetch_grants_o),
    .perf_inject_grants_o (perf_inject_grants_o),
    .perf_starve_forced_o (perf_starve_forced_o)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          src;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;

  // Reference model state
  bit          m_valid;
  logic [DW-1:0] m_data;
  bit          m_src;
  bit          m_locked;
  int          m_cnt;
  int unsigned m_pf, m_pi, m_ps;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_src = 0; m_locked = 0; m_cnt = 0;
    m_pf = 0; m_pi = 0; m_ps = 0;
    sb.delete();
  endtask

  // One clock of stimulus: predicts readies, pushes expected entries, then
  // checks the registered outputs after the edge. g: 0 none, 1 fetch, 2 inject.
  task automatic cyc(input bit fv, input logic [DW-1:0] fd, input bit iv,
                     input logic [DW-1:0] idat, input bit il, input bit a,
                     input bit fl, output int g);
    bit   space, ef, ei;
    exp_t e;
    fetch_valid_i  = fv;
    fetch_data_i   = fd;
    inject_valid_i = iv;
    inject_data_i  = idat;
    inject_last_i  = il;
    issue_ack_i    = a;
    flush_i        = fl;
    #1;
    space = !m_valid || a;
    ef = 0;
    ei = 0;
    if (!fl && space) begin
      if (m_locked) ei = iv;
      else begin
        ei = iv && (!fv || m_cnt == LIMIT);
        ef = fv && !ei;
      end
    end
    total++;
    if (fetch_ready_o !== ef) begin
      bad++;
      $display("FAIL fetch_ready: got %b want %b @%0t", fetch_ready_o, ef, $time);
    end
    total++;
    if (inject_ready_o !== ei) begin
      bad++;
      $display("FAIL inject_ready: got %b want %b @%0t", inject_ready_o, ei, $time);
    end
    g = ei ? 2 : (ef ? 1 : 0);
    if (fl) begin
      m_valid = 0; m_locked = 0; m_cnt = 0;
    end else if (ei) begin
      if (!m_locked && fv) m_ps++;
      m_pi++;
      sb.push_back('{data: idat, src: 1'b1});
      m_valid = 1; m_data = idat; m_src = 1; m_cnt = 0;
      if (!m_locked && !il) m_locked = 1;
      else if (m_locked && il) m_locked = 0;
    end else begin
      if (ef) begin
        m_pf++;
        sb.push_back('{data: fd, src: 1'b0});
        m_valid = 1; m_data = fd; m_src = 0;
      end else if (a) begin
        m_valid = 0;
      end
      if (!m_locked && iv && (ef || !space) && m_cnt < LIMIT) m_cnt++;
    end
    @(posedge clk);
    #1;
    total++;
    if (issue_valid_o !== m_valid) begin
      bad++;
      $display("FAIL issue_valid: got %b want %b @%0t", issue_valid_o, m_valid, $time);
    end
    total++;
    if (lock_o !== m_locked) begin
      bad++;
      $display("FAIL lock: got %b want %b @%0t", lock_o, m_locked, $time);
    end
    if (g != 0) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL scoreboard: empty on grant @%0t", $time);
      end else begin
        e = sb.pop_front();
        if (issue_data_o !== e.data || issue_src_o !== e.src) begin
          bad++;
          $display("FAIL issue_entry: got %h/%b want %h/%b @%0t",
                   issue_data_o, issue_src_o, e.data, e.src, $time);
        end
      end
    end else if (m_valid) begin
      total++;
      if (issue_data_o !== m_data || issue_src_o !== m_src) begin
        bad++;
        $display("FAIL hold_entry: got %h/%b want %h/%b @%0t",
                 issue_data_o, issue_src_o, m_data, m_src, $time);
      end
    end
`ifdef ID_ISSUE_ARB_PERF_EN
    total++;
    if (perf_fetch_grants_o !== m_pf || perf_inject_grants_o !== m_pi ||
        perf_starve_forced_o !== m_ps) begin
      bad++;
      $display("FAIL perf: got %0d/%0d/%0d want %0d/%0d/%0d @%0t",
               perf_fetch_grants_o, perf_inject_grants_o, perf_starve_forced_o,
               m_pf, m_pi, m_ps, $time);
    end
`endif
  endtask

  task automatic test_reset();
    rst_i = 1'b1; flush_i = 1'b0; issue_ack_i = 1'b0;
    fetch_valid_i = 1'b1; fetch_data_i = 64'h1; inject_valid_i = 1'b1;
    inject_data_i = 64'h2; inject_last_i = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (fetch_ready_o !== 1'b0 || inject_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready: got %b/%b want 0/0", fetch_ready_o, inject_ready_o);
    end
    @(posedge clk);
    #1;
    total++;
    if (issue_valid_o !== 1'b0 || issue_data_o !== '0 || issue_src_o !== 1'b0 || lock_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got v=%b d=%h s=%b l=%b want all 0",
               issue_valid_o, issue_data_o, issue_src_o, lock_o);
    end
    rst_i = 1'b0;
    model_reset();
  endtask

  task automatic test_fetch_stream();
    int g;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 64'h10 + 64'(i), 0, '0, 1, 1, 0, g);
      total++;
      if (g != 1 || issue_data_o !== 64'h10 + 64'(i) || issue_valid_o !== 1'b1) begin
        bad++;
        $display("FAIL fetch_stream[%0d]: got g=%0d d=%h v=%b want g=1 d=%h v=1",
                 i, g, issue_data_o, issue_valid_o, 64'h10 + 64'(i));
      end
    end
    cyc(0, '0, 0, '0, 1, 1, 0, g);
  endtask

  task automatic test_contention();
    int g;
    int want;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 64'h200 + 64'(i), 1, 64'h300 + 64'(i), 1, 1, 0, g);
      want = (i % 5 == 4) ? 2 : 1;
      total++;
      if (g != want) begin
        bad++;
        $display("FAIL contention[%0d]: got grant %0d want %0d", i, g, want);
      end
`ifdef ID_ISSUE_ARB_PERF_EN
      if (i == 4) begin
        total++;
        if (perf_starve_forced_o !== 32'd1) begin
          bad++;
          $display("FAIL starve_forced: got %0d want 1", perf_starve_forced_o);
        end
      end
`endif
    end
  endtask

  task automatic test_lock_sequence();
    int g;
    int k;
    int fetch_in_lock;
    k = 0;
    g = 0;
    while (g != 2 && k < 8) begin
      cyc(1, 64'h400 + 64'(k), 1, 64'h501, 0, 1, 0, g);
      k++;
    end
    total++;
    if (g != 2 || lock_o !== 1'b1) begin
      bad++;
      $display("FAIL lock_enter: got grant %0d lock %b after %0d cycles want 2/1", g, lock_o, k);
    end
    fetch_in_lock = 0;
    cyc(1, 64'h410, 0, '0, 0, 1, 0, g);
    if (g == 1) fetch_in_lock++;
    cyc(1, 64'h411, 1, 64'h502, 0, 1, 0, g);
    if (g == 1) fetch_in_lock++;
    total++;
    if (lock_o !== 1'b1) begin
      bad++;
      $display("FAIL lock_hold: got %b want 1", lock_o);
    end
    cyc(1, 64'h412, 1, 64'h503, 1, 1, 0, g);
    if (g == 1) fetch_in_lock++;
    total++;
    if (fetch_in_lock != 0 || lock_o !== 1'b0 || issue_data_o !== 64'h503) begin
      bad++;
      $display("FAIL lock_exit: got fetches=%0d lock=%b d=%h want 0/0/503",
               fetch_in_lock, lock_o, issue_data_o);
    end
  endtask

  task automatic test_back_pressure();
    int g;
    cyc(1, 64'hAA, 0, '0, 1, 1, 0, g);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 64'hCC, 1, 64'h77, 1, 0, 0, g);
      total++;
      if (g != 0 || issue_data_o !== 64'hAA) begin
        bad++;
        $display("FAIL backpressure[%0d]: got grant %0d d=%h want 0/aa", i, g, issue_data_o);
      end
    end
    cyc(1, 64'hBB, 0, '0, 1, 1, 0, g);
    total++;
    if (g != 1 || issue_data_o !== 64'hBB || issue_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL release: got grant %0d d=%h v=%b want 1/bb/1", g, issue_data_o, issue_valid_o);
    end
  endtask

  task automatic test_flush();
    int g;
    // Counter is saturated here; a flush must clear it so fetch wins next.
    cyc(1, 64'hDD, 1, 64'h66, 1, 0, 1, g);
    cyc(1, 64'hE0, 1, 64'h67, 1, 1, 0, g);
    total++;
    if (g != 1) begin
      bad++;
      $display("FAIL flush_clears_starve: got grant %0d want 1", g);
    end
    cyc(0, '0, 1, 64'h80, 0, 1, 0, g);
    cyc(1, 64'hE1, 1, 64'h81, 1, 1, 1, g);
    total++;
    if (g != 0 || issue_valid_o !== 1'b0 || lock_o !== 1'b0 || issue_data_o !== 64'h80) begin
      bad++;
      $display("FAIL flush_locked: got g=%0d v=%b l=%b d=%h want 0/0/0/80",
               g, issue_valid_o, lock_o, issue_data_o);
    end
    cyc(1, 64'hF0, 1, 64'h82, 1, 1, 0, g);
    total++;
    if (g != 1) begin
      bad++;
      $display("FAIL post_flush_grant: got grant %0d want 1", g);
    end
  endtask

  task automatic test_reset_mid_lock();
    int g;
    cyc(0, '0, 1, 64'h90, 0, 1, 0, g);
    rst_i = 1'b1;
    fetch_valid_i = 1'b1; inject_valid_i = 1'b1; issue_ack_i = 1'b1;
    #1;
    total++;
    if (fetch_ready_o !== 1'b0 || inject_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_ready: got %b/%b want 0/0", fetch_ready_o, inject_ready_o);
    end
    @(posedge clk);
    #1;
    total++;
    if (issue_valid_o !== 1'b0 || issue_data_o !== '0 || issue_src_o !== 1'b0 || lock_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_state: got v=%b d=%h s=%b l=%b want all 0",
               issue_valid_o, issue_data_o, issue_src_o, lock_o);
    end
`ifdef ID_ISSUE_ARB_PERF_EN
    total++;
    if (perf_fetch_grants_o !== '0 || perf_inject_grants_o !== '0 || perf_starve_forced_o !== '0) begin
      bad++;
      $display("FAIL reset_perf: got %0d/%0d/%0d want 0/0/0",
               perf_fetch_grants_o, perf_inject_grants_o, perf_starve_forced_o);
    end
`endif
    rst_i = 1'b0;
    model_reset();
    cyc(1, 64'hC1, 1, 64'hC2, 1, 1, 0, g);
  endtask

  initial begin
    test_reset();
    test_fetch_stream();
    test_contention();
    test_lock_sequence();
    test_back_pressure();
    test_flush();
    test_reset_mid_lock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
